// File: rtl/fetch_buffer_pkg.sv
// Shared fetch-path types and constants for the fetch buffer and its queue.
package fetch_buffer_pkg;
  localparam int XLEN = 32;
  localparam int INST_BYTES = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Circular {inst, pc} queue: synchronous write, asynchronous head read, wrapping pointers.
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr_en,
  input  fetch_entry_t wr_data,
  input  logic         rd_en,
  output fetch_entry_t rd_data
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] head, tail;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (wr_en) tail <= bump(tail);
      if (rd_en) head <= bump(head);
    end
  end

  // Data array carries no reset; occupancy in the parent guards every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= wr_data;
  end

  assign rd_data = mem[head];
endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: PC/request control in front of a small instruction queue.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_buffer #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
)(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] inst_addr_o,
  output logic            inst_ce_o,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  input  logic            id_ready_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_inst_o,
  output logic [XLEN-1:0] id_pc_o
);
  import fetch_buffer_pkg::*;

  localparam int CW = $clog2(DEPTH+1);

  if (XLEN != fetch_buffer_pkg::XLEN || DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0) begin : g_cfg_err
    $error("fetch_buffer: XLEN must match the package and DEPTH must be a power of two >= 2");
  end

  logic [XLEN-1:0] fetch_pc, pend_pc;
  logic [CW-1:0]   count;
  logic            pending, req, byp, wr_en, rd_en;
  fetch_entry_t    head, wr_entry;
  logic            unused_ok;

  assign unused_ok = ^flush_pc_i[1:0];

  // Reserve a slot for the in-flight response so the queue can never overflow.
  assign req         = !rst && !flush_i && (int'(count) + int'(pending) < DEPTH);
  assign inst_ce_o   = req;
  assign inst_addr_o = fetch_pc;

`ifdef FETCH_BYPASS_EN
  assign byp = pending && (count == '0);
`else
  assign byp = 1'b0;
`endif

  assign id_valid_o = !flush_i && ((count != '0) || byp);
  assign id_inst_o  = !id_valid_o ? NOP : (byp ? inst_i : head.inst);
  assign id_pc_o    = byp ? pend_pc : head.pc;

  assign rd_en    = id_valid_o && id_ready_i && !byp;
  assign wr_en    = pending && !flush_i && !(byp && id_ready_i);
  assign wr_entry = '{inst: inst_i, pc: pend_pc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
      count    <= '0;
      pending  <= 1'b0;
    end else if (flush_i) begin
      fetch_pc <= {flush_pc_i[XLEN-1:2], 2'b00};
      count    <= '0;
      pending  <= 1'b0;
    end else begin
      pending <= req;
      if (req) begin
        pend_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
      end
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush_i),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (head)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && !rd_en && count == CW'(DEPTH)));
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue-based reference model plus directed literal checks.
module tb_fetch_buffer;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed { logic [31:0] inst; logic [31:0] pc; } ent_t;

  logic        clk = 1'b0, rst = 1'b1, flush_i = 1'b0, id_ready_i = 1'b0;
  logic [31:0] flush_pc_i = '0, inst_i, inst_addr_o, id_inst_o, id_pc_o;
  logic        inst_ce_o, id_valid_o;

  always #5 clk = ~clk;

  fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_o(inst_addr_o), .inst_ce_o(inst_ce_o),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i), .id_ready_i(id_ready_i),
    .id_valid_o(id_valid_o), .id_inst_o(id_inst_o), .id_pc_o(id_pc_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_0013;
  endfunction

  // Instruction memory: answers one cycle after each strobe.
  logic        resp_vld;
  logic [31:0] resp_addr;
  always @(posedge clk or posedge rst) begin
    if (rst) resp_vld <= 1'b0;
    else begin
      resp_vld  <= inst_ce_o;
      resp_addr <= inst_addr_o;
    end
  end
  assign inst_i = resp_vld ? mem_word(resp_addr) : 32'hDEAD_BEEF;

  int passed = 0, total = 0;
  int ce_cnt = 0;
  bit seen_200 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  // Reference model: queue of fetched entries, one outstanding request, fetch PC.
  ent_t        q[$];
  bit          m_pend;
  logic [31:0] m_ppc, m_fpc, last_pc;
  bit          have_last;

  initial begin : cmp_proc
    bit   exp_ce, exp_valid, byp_now, took;
    int   n;
    ent_t head;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete(); m_pend = 0; m_fpc = RESET_PC; m_ppc = RESET_PC; have_last = 0;
        chk("rst_ce", {31'b0, inst_ce_o}, 32'd0);
        chk("rst_valid", {31'b0, id_valid_o}, 32'd0);
        chk("rst_addr", inst_addr_o, RESET_PC);
      end else begin
        n         = q.size();
        exp_ce    = !flush_i && (n + int'(m_pend) < DEPTH);
        byp_now   = BYP && m_pend && n == 0;
        exp_valid = !flush_i && (n > 0 || byp_now);
        if (n > 0) head = q[0];
        else begin
          head.inst = mem_word(m_ppc);
          head.pc   = m_ppc;
        end
        chk("ce", {31'b0, inst_ce_o}, {31'b0, exp_ce});
        if (exp_ce) chk("addr", inst_addr_o, m_fpc);
        chk("valid", {31'b0, id_valid_o}, {31'b0, exp_valid});
        if (exp_valid) begin
          chk("id_pc", id_pc_o, head.pc);
          chk("id_inst", id_inst_o, head.inst);
        end
        if (inst_ce_o) ce_cnt++;
        took = exp_valid && id_ready_i;
        if (took) begin
          if (id_pc_o == 32'h200) seen_200 = 1'b1;
          if (have_last) chk("pc_step", id_pc_o, last_pc + 32'd4);
          have_last = 1'b1;
          last_pc   = head.pc;
        end
        if (flush_i) begin
          q.delete(); m_pend = 0; have_last = 0;
          m_fpc = {flush_pc_i[31:2], 2'b00};
        end else begin
          if (took && n > 0) void'(q.pop_front());
          if (m_pend && !(took && n == 0)) q.push_back({mem_word(m_ppc), m_ppc});
          if (exp_ce) begin
            m_ppc = m_fpc;
            m_fpc = m_fpc + 32'd4;
          end
          m_pend = exp_ce;
        end
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  initial begin
    // Reset release and first fetches
    rst = 1'b1; id_ready_i = 1'b1;
    cyc(3);
    @(negedge clk);
    chk("s1_rst_ce", {31'b0, inst_ce_o}, 32'd0);
    chk("s1_rst_addr", inst_addr_o, 32'h0);
    cyc(1); rst = 1'b0;
    @(negedge clk);
    chk("s1_c0_ce", {31'b0, inst_ce_o}, 32'd1);
    chk("s1_c0_addr", inst_addr_o, 32'h0);
    cyc(1); @(negedge clk);
    chk("s1_c1_addr", inst_addr_o, 32'h4);
    chk("s1_c1_valid", {31'b0, id_valid_o}, BYP ? 32'd1 : 32'd0);
    cyc(1); @(negedge clk);
    chk("s1_c2_valid", {31'b0, id_valid_o}, 32'd1);
    chk("s1_c2_pc", id_pc_o, BYP ? 32'h4 : 32'h0);
    chk("s1_c2_addr", inst_addr_o, 32'h8);
    cyc(1); @(negedge clk);
    chk("s1_c3_pc", id_pc_o, BYP ? 32'h8 : 32'h4);

    // Stall decode: exactly DEPTH requests, then in-order drain without gaps
    cyc(1); flush_i = 1'b1; flush_pc_i = 32'h80; id_ready_i = 1'b0;
    @(negedge clk);
    chk("s2_flush_ce", {31'b0, inst_ce_o}, 32'd0);
    chk("s2_flush_valid", {31'b0, id_valid_o}, 32'd0);
    cyc(1); flush_i = 1'b0; ce_cnt = 0;
    cyc(10);
    chk("s2_req_count", ce_cnt, 32'd4);
    @(negedge clk);
    chk("s2_full_ce", {31'b0, inst_ce_o}, 32'd0);
    chk("s2_full_pc", id_pc_o, 32'h80);
    cyc(1); id_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s2_drain_valid", {31'b0, id_valid_o}, 32'd1);
      chk("s2_drain_pc", id_pc_o, 32'h80 + 32'(4*i));
      cyc(1);
    end

    // Flush with unaligned target while nearly full and a response pending
    flush_i = 1'b1; flush_pc_i = 32'h80; id_ready_i = 1'b0;
    cyc(1); flush_i = 1'b0;
    cyc(4); flush_i = 1'b1; flush_pc_i = 32'h103;
    @(negedge clk);
    chk("s3_flush_ce", {31'b0, inst_ce_o}, 32'd0);
    chk("s3_flush_valid", {31'b0, id_valid_o}, 32'd0);
    cyc(1); flush_i = 1'b0;
    @(negedge clk);
    chk("s3_t1_addr", inst_addr_o, 32'h100);
    chk("s3_t1_valid", {31'b0, id_valid_o}, 32'd0);
    cyc(1); @(negedge clk);
    chk("s3_t2_valid", {31'b0, id_valid_o}, BYP ? 32'd1 : 32'd0);
    cyc(1); @(negedge clk);
    chk("s3_t3_valid", {31'b0, id_valid_o}, 32'd1);
    chk("s3_t3_pc", id_pc_o, 32'h100);

    // Back-to-back flushes: last one wins
    cyc(1); seen_200 = 1'b0; id_ready_i = 1'b1; flush_i = 1'b1; flush_pc_i = 32'h200;
    cyc(1); flush_pc_i = 32'h300;
    @(negedge clk);
    chk("s4_t1_ce", {31'b0, inst_ce_o}, 32'd0);
    cyc(1); flush_i = 1'b0;
    @(negedge clk);
    chk("s4_t2_addr", inst_addr_o, 32'h300);
    cyc(1); @(negedge clk);
    chk("s4_t3_valid", {31'b0, id_valid_o}, BYP ? 32'd1 : 32'd0);
    cyc(1); @(negedge clk);
    chk("s4_t4_pc", id_pc_o, BYP ? 32'h304 : 32'h300);
    chk("s4_no_200", {31'b0, seen_200}, 32'd0);

    // Asynchronous reset mid-stream
    cyc(1); flush_i = 1'b1; flush_pc_i = 32'h38;
    cyc(1); flush_i = 1'b0;
    cyc(2); @(negedge clk);
    chk("s5_addr", inst_addr_o, 32'h40);
    #2 rst = 1'b1;
    #1;
    chk("s5_async_ce", {31'b0, inst_ce_o}, 32'd0);
    chk("s5_async_valid", {31'b0, id_valid_o}, 32'd0);
    chk("s5_async_addr", inst_addr_o, RESET_PC);
    cyc(2); rst = 1'b0;
    @(negedge clk);
    chk("s5_restart_ce", {31'b0, inst_ce_o}, 32'd1);
    chk("s5_restart_addr", inst_addr_o, RESET_PC);

    // Random decode back-pressure across the address wrap
    cyc(1); flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFE0;
    cyc(1); flush_i = 1'b0;
    repeat (300) begin
      id_ready_i = 1'($urandom_range(0, 1));
      cyc(1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
